// File: rtl/interp_10x_sequencer.sv
// interp_10x_sequencer: sample feed and strobe generator for the 10x interpolator atoms.
// Samples arrive over valid/ready into a one-entry holding register and are shifted
// into a 3-deep delay line once per input period (10 frames of 10 ticks).
module interp_10x_sequencer #(
   parameter int unsigned DIV = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   output logic       clk_en,
   output logic       clk_en_10x,
   output logic       msb_stage,
   output logic       end_stage,
   output logic [3:0] phase,
   output logic [7:0] sample_x0,
   output logic [7:0] sample_x1,
   output logic [7:0] sample_x2,
   output logic       underrun,
   output logic       busy
);

   localparam logic [7:0] PRE_LAST = 8'(DIV - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [7:0] pre;
   logic [3:0] tick;
   logic [3:0] phase_cnt;
   logic [7:0] hold;
   logic       full;
   logic       start;
   logic       tick_strobe;
   logic       frame_wrap;
   logic       load;
   logic       take;

   // Sequencer state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next state plus the per-cycle decodes: start, tick strobe, frame wrap, delay-line load
   always_comb begin
      state_next  = state;
      start       = 1'b0;
      tick_strobe = 1'b0;
      frame_wrap  = 1'b0;
      load        = 1'b0;
      case (state)
         IDLE: begin
            if (run) begin
               state_next = RUN;
               start      = 1'b1;
               load       = 1'b1;
            end
         end
         RUN: begin
            tick_strobe = (pre == 8'd0);
            frame_wrap  = (pre == PRE_LAST) && (tick == 4'd9);
            if (frame_wrap) begin
               if (!run)                    state_next = IDLE;
               else if (phase_cnt == 4'd9)  load       = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      s_ready = !full || load;
      take    = s_valid && s_ready;
   end

   // Prescaler, tick and phase counters; a start always begins a fresh phase-0 frame
   always_ff @(posedge clk) begin
      if (reset || start) begin
         pre       <= 8'd0;
         tick      <= 4'd0;
         phase_cnt <= 4'd0;
      end else if (state == RUN) begin
         if (pre == PRE_LAST) begin
            pre  <= 8'd0;
            tick <= (tick == 4'd9) ? 4'd0 : tick + 4'd1;
         end else begin
            pre <= pre + 8'd1;
         end
         if (frame_wrap) phase_cnt <= (phase_cnt == 4'd9) ? 4'd0 : phase_cnt + 4'd1;
      end
   end

   // Registered strobes describe the previous cycle's counters; phase freezes in IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_en_10x <= 1'b0;
         clk_en     <= 1'b0;
         msb_stage  <= 1'b0;
         end_stage  <= 1'b0;
         busy       <= 1'b0;
         phase      <= 4'd0;
      end else begin
         clk_en_10x <= tick_strobe;
         clk_en     <= tick_strobe && (tick == 4'd0);
         msb_stage  <= tick_strobe && (tick == 4'd8);
         end_stage  <= tick_strobe && (tick == 4'd9);
         busy       <= (state == RUN);
         if (state == RUN) phase <= phase_cnt;
      end
   end

   // Holding register: a same-cycle load and transfer leaves it full with the new sample
   always_ff @(posedge clk) begin
      if (reset) begin
         hold <= 8'd0;
         full <= 1'b0;
      end else if (take) begin
         hold <= s_data;
         full <= 1'b1;
      end else if (load) begin
         full <= 1'b0;
      end
   end

   // Delay line shift; an empty holding register injects zero and latches the sticky underrun
   always_ff @(posedge clk) begin
      if (reset) begin
         sample_x0 <= 8'd0;
         sample_x1 <= 8'd0;
         sample_x2 <= 8'd0;
         underrun  <= 1'b0;
      end else if (load) begin
         sample_x2 <= sample_x1;
         sample_x1 <= sample_x0;
         sample_x0 <= full ? hold : 8'd0;
         if (!full) underrun <= 1'b1;
      end
   end

endmodule
